// File: rtl/stream_monitor_pkg.sv
// Shared types and helpers for the passive stream monitor.
// Saturation limits are derived from a counter width of up to 64 bits.
package stream_monitor_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_e;

    localparam int unsigned MaxCntWidth = 64;

    function automatic logic [MaxCntWidth-1:0] cnt_limit(input int unsigned width);
        if (width >= MaxCntWidth) return '1;
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/stream_monitor_cnt.sv
// Saturating event counter: clears on clr_i, otherwise counts inc_i and sticks at all-ones.
module stream_monitor_cnt
    import stream_monitor_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    localparam logic [MaxCntWidth-1:0] LimitFull = cnt_limit(Width);
    localparam logic [Width-1:0]       Limit     = LimitFull[Width-1:0];

    logic [Width-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                         cnt_d = '0;
        else if (inc_i && cnt_q != Limit)  cnt_d = cnt_q + Width'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/stream_monitor.sv
// Passive valid/ready tap: counts handshakes and stalls, tracks the longest stall run,
// and raises sticky protocol-violation flags for a transfer left pending.
module stream_monitor
    import stream_monitor_pkg::*;
#(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned CntWidth  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic                 ready_i,
    input  logic [DataWidth-1:0] data_i,
    output logic [CntWidth-1:0]  hs_cnt_o,
    output logic [CntWidth-1:0]  stall_cnt_o,
    output logic [CntWidth-1:0]  max_stall_o,
    output logic                 data_err_o,
    output logic                 valid_err_o,
    output logic [DataWidth-1:0] err_data_o
);

    localparam logic [MaxCntWidth-1:0] LimitFull = cnt_limit(CntWidth);
    localparam logic [CntWidth-1:0]    CntMax    = LimitFull[CntWidth-1:0];

    state_e               state_q;
    logic [DataWidth-1:0] hold_q, err_data_q;
    logic [CntWidth-1:0]  run_d, run_q, max_d, max_q;
    logic                 data_err_q, valid_err_q;
    logic                 hs, stall, pend, derr, verr;

    assign hs    = valid_i && ready_i;
    assign stall = valid_i && !ready_i;
    assign pend  = (state_q == PENDING);
    assign derr  = pend && (data_i != hold_q);
    assign verr  = pend && !valid_i;

    always_comb begin
        run_d = '0;
        if (stall) run_d = (run_q == CntMax) ? run_q : run_q + CntWidth'(1);
        max_d = (run_d > max_q) ? run_d : max_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            run_q       <= '0;
            max_q       <= '0;
            data_err_q  <= 1'b0;
            valid_err_q <= 1'b0;
            err_data_q  <= '0;
        end else if (clear_i) begin
            state_q     <= IDLE;
            run_q       <= '0;
            max_q       <= '0;
            data_err_q  <= 1'b0;
            valid_err_q <= 1'b0;
            err_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (stall) begin
                    state_q <= PENDING;
                    hold_q  <= data_i;
                end
                PENDING: if (hs || !valid_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            run_q <= run_d;
            max_q <= max_d;
            if (derr) data_err_q  <= 1'b1;
            if (verr) valid_err_q <= 1'b1;
            // Only the first violation since reset/clear records its payload.
            if ((derr || verr) && !data_err_q && !valid_err_q) err_data_q <= hold_q;
        end
    end

    stream_monitor_cnt #(.Width(CntWidth)) u_hs_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .inc_i (hs),
        .cnt_o (hs_cnt_o)
    );

    stream_monitor_cnt #(.Width(CntWidth)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (clear_i),
        .inc_i (stall),
        .cnt_o (stall_cnt_o)
    );

    assign max_stall_o = max_q;
    assign data_err_o  = data_err_q;
    assign valid_err_o = valid_err_q;
    assign err_data_o  = err_data_q;

endmodule

// File: tb/tb_stream_monitor.sv
// Scoreboard bench: stimulus queues hand-computed expectations tagged with the cycle
// they become visible; the monitor pops and compares them.
module tb_stream_monitor;

    localparam int DW = 8;

    logic clk = 1'b0, rst = 1'b1, clr = 1'b0, v = 1'b0, r = 1'b0;
    logic [DW-1:0] d = '0;
    logic v2 = 1'b0, r2 = 1'b0, clr2 = 1'b0;
    logic [DW-1:0] d2 = '0;

    logic [7:0] hs1, st1, mx1;
    logic de1, ve1;
    logic [DW-1:0] ed1;
    logic [3:0] hs2, st2, mx2;
    logic de2, ve2;
    logic [DW-1:0] ed2;

    stream_monitor #(.DataWidth(DW), .CntWidth(8)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .valid_i(v), .ready_i(r), .data_i(d),
        .hs_cnt_o(hs1), .stall_cnt_o(st1), .max_stall_o(mx1),
        .data_err_o(de1), .valid_err_o(ve1), .err_data_o(ed1)
    );

    stream_monitor #(.DataWidth(DW), .CntWidth(4)) dut_sat (
        .clk_i(clk), .rst_i(rst), .clear_i(clr2), .valid_i(v2), .ready_i(r2), .data_i(d2),
        .hs_cnt_o(hs2), .stall_cnt_o(st2), .max_stall_o(mx2),
        .data_err_o(de2), .valid_err_o(ve2), .err_data_o(ed2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    cyc;
        string name;
        bit    sel;
        int    hs, st, mx;
        bit    de, ve;
        int    ed;
    } exp_t;

    exp_t q[$];
    int n_chk = 0, n_pass = 0;
    event now_ev;

    // Monitor: compare every expectation due in the current cycle.
    initial begin
        exp_t e;
        int ahs, ast, amx, aed;
        bit ade, ave;
        forever begin
            @(negedge clk or now_ev);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                n_chk++;
                ahs = e.sel ? int'(hs2) : int'(hs1);
                ast = e.sel ? int'(st2) : int'(st1);
                amx = e.sel ? int'(mx2) : int'(mx1);
                ade = e.sel ? de2 : de1;
                ave = e.sel ? ve2 : ve1;
                aed = e.sel ? int'(ed2) : int'(ed1);
                if (e.cyc < cyc)
                    $display("FAIL %s: not checked in due cycle %0d (now %0d)", e.name, e.cyc, cyc);
                else if (ahs != e.hs || ast != e.st || amx != e.mx ||
                         ade != e.de || ave != e.ve || aed != e.ed)
                    $display("FAIL %s: got hs=%0d st=%0d mx=%0d de=%0b ve=%0b ed=%0h, want hs=%0d st=%0d mx=%0d de=%0b ve=%0b ed=%0h",
                             e.name, ahs, ast, amx, ade, ave, aed,
                             e.hs, e.st, e.mx, e.de, e.ve, e.ed);
                else
                    n_pass++;
            end
        end
    end

    task automatic step(input bit vv, input bit rr, input logic [DW-1:0] dd, input bit cc);
        @(posedge clk); #1;
        v = vv; r = rr; d = dd; clr = cc;
    endtask

    task automatic step2(input bit vv, input bit rr);
        @(posedge clk); #1;
        v2 = vv; r2 = rr;
    endtask

    task automatic expect_at(input int dly, input string nm, input bit s, input int hs,
                             input int st, input int mx, input bit de, input bit ve, input int ed);
        exp_t e;
        e.cyc = cyc + dly; e.name = nm; e.sel = s;
        e.hs = hs; e.st = st; e.mx = mx; e.de = de; e.ve = ve; e.ed = ed;
        q.push_back(e);
    endtask

    // Expectation visible after the next rising edge (main instance).
    task automatic chk(input string nm, input int hs, input int st, input int mx,
                       input bit de, input bit ve, input int ed);
        expect_at(1, nm, 1'b0, hs, st, mx, de, ve, ed);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, checked while reset is still asserted.
        @(posedge clk); #1;
        expect_at(0, "reset_main", 1'b0, 0, 0, 0, 0, 0, 0);
        expect_at(0, "reset_sat",  1'b1, 0, 0, 0, 0, 0, 0);
        -> now_ev;
        @(posedge clk); #1 rst = 1'b0;

        // CntWidth=4: 20 handshakes saturate at 15, then 18 stalls saturate stall/max.
        for (int k = 1; k <= 20; k++) begin
            step2(1'b1, 1'b1);
            if (k == 14 || k == 15 || k == 16 || k == 20)
                expect_at(1, "sat_hs", 1'b1, (k > 15) ? 15 : k, 0, 0, 0, 0, 0);
        end
        for (int k = 1; k <= 18; k++) begin
            step2(1'b1, 1'b0);
            if (k == 15 || k == 18)
                expect_at(1, "sat_stall", 1'b1, 15, 15, 15, 0, 0, 0);
        end
        step2(1'b1, 1'b1);
        expect_at(1, "sat_hold_hs", 1'b1, 15, 15, 15, 0, 0, 0);
        step2(1'b0, 1'b0);
        expect_at(1, "sat_hold_idle", 1'b1, 15, 15, 15, 0, 0, 0);

        // Back-to-back handshakes.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, DW'(i), 1'b0);
            chk("hs_b2b", i, 0, 0, 0, 0, 0);
        end
        step(1'b0, 1'b0, 8'h00, 1'b0); chk("hs_idle", 5, 0, 0, 0, 0, 0);

        // Three stall cycles then a handshake.
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("clear_b", 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 8'h11, 1'b0); chk("stall1", 0, 1, 1, 0, 0, 0);
        step(1'b1, 1'b0, 8'h11, 1'b0); chk("stall2", 0, 2, 2, 0, 0, 0);
        step(1'b1, 1'b0, 8'h11, 1'b0); chk("stall3", 0, 3, 3, 0, 0, 0);
        step(1'b1, 1'b1, 8'h11, 1'b0); chk("stall_hs", 1, 3, 3, 0, 0, 0);
        step(1'b0, 1'b0, 8'h00, 1'b0); chk("stall_idle", 1, 3, 3, 0, 0, 0);

        // Payload change while pending; second error keeps the first payload.
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("clear_c", 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 8'hA5, 1'b0); chk("derr_pend", 0, 1, 1, 0, 0, 0);
        step(1'b1, 1'b0, 8'h5A, 1'b0); chk("derr_first", 0, 2, 2, 1, 0, 'hA5);
        step(1'b1, 1'b0, 8'h3C, 1'b0); chk("derr_second", 0, 3, 3, 1, 0, 'hA5);
        step(1'b1, 1'b1, 8'hA5, 1'b0); chk("derr_hs", 1, 3, 3, 1, 0, 'hA5);
        step(1'b0, 1'b0, 8'h00, 1'b0); chk("derr_sticky", 1, 3, 3, 1, 0, 'hA5);

        // Valid drop while pending; FSM must be back in IDLE afterwards.
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("clear_d", 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 8'h77, 1'b0); chk("verr_pend", 0, 1, 1, 0, 0, 0);
        step(1'b0, 1'b0, 8'h77, 1'b0); chk("verr_flag", 0, 1, 1, 0, 1, 'h77);
        step(1'b1, 1'b1, 8'h88, 1'b0); chk("verr_idle_hs", 1, 1, 1, 0, 1, 'h77);

        // Both violations in one cycle.
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("clear_d2", 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 8'h10, 1'b0); chk("both_pend", 0, 1, 1, 0, 0, 0);
        step(1'b0, 1'b0, 8'h20, 1'b0); chk("both_flags", 0, 1, 1, 1, 1, 'h10);
        step(1'b0, 1'b0, 8'h00, 1'b0); chk("both_sticky", 0, 1, 1, 1, 1, 'h10);

        // Clear wins over a simultaneous handshake, and over a pending transfer.
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("clear_e", 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 8'h01, 1'b0); chk("clr_pre_hs", 1, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 8'h02, 1'b1); chk("clr_with_hs", 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 8'h33, 1'b0); chk("clr_pre_pend", 0, 1, 1, 0, 0, 0);
        step(1'b1, 1'b0, 8'h44, 1'b1); chk("clr_pend", 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b1, 8'h55, 1'b0); chk("clr_fsm_idle", 1, 0, 0, 0, 0, 0);

        // Reset mid-stall clears outputs before any clock edge; pending transfer is dropped.
        step(1'b0, 1'b0, 8'h00, 1'b1); chk("clear_f", 0, 0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 8'h66, 1'b0); chk("rst_stall1", 0, 1, 1, 0, 0, 0);
        step(1'b1, 1'b0, 8'h66, 1'b0); chk("rst_stall2", 0, 2, 2, 0, 0, 0);
        step(1'b1, 1'b0, 8'h66, 1'b0); chk("rst_stall3", 0, 3, 3, 0, 0, 0);
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        expect_at(0, "rst_async", 1'b0, 0, 0, 0, 0, 0, 0);
        expect_at(0, "rst_async_sat", 1'b1, 0, 0, 0, 0, 0, 0);
        -> now_ev;
        step(1'b1, 1'b0, 8'h66, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; v = 1'b0; r = 1'b0; d = 8'h00;
        chk("rst_no_verr", 0, 0, 0, 0, 0, 0);
        step(1'b0, 1'b0, 8'h00, 1'b0); chk("rst_quiet", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk); #1;
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stream_monitor.md
STREAM_MONITOR -- requirements
Module: stream_monitor

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of the monitored payload.
REQ-002 SHALL have parameter CntWidth, default 32, width of every statistics counter.
REQ-003 SHALL have port clk_i  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port clear_i  input  1  synchronous clear of counters and sticky flags.
REQ-006 SHALL have port valid_i  input  1  observed stream valid (passive tap).
REQ-007 SHALL have port ready_i  input  1  observed stream ready (passive tap).
REQ-008 SHALL have port data_i  input  DataWidth  observed stream payload.
REQ-009 SHALL have port hs_cnt_o  output  CntWidth  completed handshakes (valid_i && ready_i).
REQ-010 SHALL have port stall_cnt_o  output  CntWidth  cycles with valid_i && !ready_i.
REQ-011 SHALL have port max_stall_o  output  CntWidth  longest consecutive stall run seen.
REQ-012 SHALL have port data_err_o  output  1  sticky: payload changed while a transfer was pending.
REQ-013 SHALL have port valid_err_o  output  1  sticky: valid dropped while a transfer was pending.
REQ-014 SHALL have port err_data_o  output  DataWidth  payload held at the pending cycle of the first error.

Function
REQ-015 SHALL be purely passive: no output drives or influences the monitored stream.
REQ-016 SHALL implement FSM states IDLE and PENDING.
- IDLE -> PENDING when valid_i && !ready_i; data_i is latched into a hold register.
- PENDING -> IDLE when valid_i && ready_i, or on a valid drop.
- Otherwise the state holds.
REQ-017 SHALL, in PENDING, flag data_err_o one cycle after a cycle where data_i != hold register.
REQ-018 SHALL, in PENDING, flag valid_err_o one cycle after a cycle where !valid_i.
REQ-019 SHALL, on a cycle where both errors occur, set both flags in the same cycle.
REQ-020 SHALL keep error flags set until clear_i or rst_i.
REQ-021 SHALL capture err_data_o only on the first error after reset or clear; later errors do not overwrite it.
REQ-022 SHALL count handshakes in hs_cnt_o with one cycle latency (registered output).
REQ-023 SHALL count stall cycles in stall_cnt_o with one cycle latency (registered output).
REQ-024 SHALL track the current stall run length internally, resetting it to 0 on any non-stall cycle.
REQ-025 SHALL update max_stall_o whenever the current run exceeds it.
REQ-026 SHALL saturate every counter at 2^CntWidth-1 with no wrap-around; the other counters are unaffected.
REQ-027 SHALL give clear_i priority over a simultaneous event: that cycle's event is not counted, counters read 0 next cycle, and the FSM returns to IDLE.
REQ-028 SHALL treat a valid_i-high cycle in IDLE with ready_i high as a single-cycle handshake: counted, no state change.

Reset
REQ-029 SHALL, while rst_i is high, set all counters, max_stall_o, data_err_o, valid_err_o and err_data_o to 0 and the FSM to IDLE, independent of clk_i.
REQ-030 SHALL treat a transfer that was pending when reset asserts as discarded; no error is flagged for it after reset releases.

Structure
REQ-031 SHALL define the FSM state enum (IDLE, PENDING) in shared package stream_monitor_pkg.
REQ-032 SHALL place counter saturation limits derived from CntWidth in stream_monitor_pkg.
REQ-033 SHALL use one sub-module, stream_monitor_cnt: saturating counter with inc_i and clr_i, instantiated for hs_cnt_o and stall_cnt_o.
REQ-034 SHALL fit in 120-400 lines of RTL in total.

Verification
REQ-035 Bench SHALL cover: 5 back-to-back handshakes (valid=ready=1) -> hs_cnt_o=5, stall_cnt_o=0, no errors.
REQ-036 Bench SHALL cover: valid=1, ready=0 for 3 cycles, then ready=1 -> stall_cnt_o=3, max_stall_o=3, hs_cnt_o=1.
REQ-037 Bench SHALL cover: pending data 0xA5, changed to 0x5A while ready=0 -> data_err_o=1 next cycle, err_data_o=0xA5; a second error leaves err_data_o=0xA5.
REQ-038 Bench SHALL cover: valid dropped while pending -> valid_err_o=1 next cycle, FSM in IDLE.
REQ-039 Bench SHALL cover: CntWidth=4 with 20 handshakes -> hs_cnt_o=15, held at 15.
REQ-040 Bench SHALL cover: clear_i asserted in the same cycle as a handshake -> all counters 0 and flags 0 next cycle; rst_i mid-stall -> all outputs 0 immediately.
